// File: rtl/sha2_pad_feeder_eddsa.sv
// rtl/sha2_pad_feeder_eddsa.sv - SHA-2 message padder and block feeder for the EdDSA hash core
//
// Takes a big-endian word stream, applies SHA-2 padding and the bit-length
// trailer, and assembles 16-word blocks. Each block is loaded into the core,
// the core runs its rounds, and the final chaining value is registered as
// the digest. The feeder drives the core's reset so that every message
// starts from the IV.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   msg_valid/msg_ready      input word handshake
//   msg_data                 message word, first byte in the MSBs
//   msg_last/msg_last_bytes  final-word marker and its byte count (0..WIDTH/8)
//   core_rst                 active-low core reset (pulsed at message start)
//   core_load/core_data      16-cycle block load into the core
//   core_start/core_end_op   round enable and round-completion from the core
//   core_h                   core chaining value
//   digest/digest_valid      registered digest and its one-cycle update pulse
//   busy                     high from the first accepted word until digest_valid
module sha2_pad_feeder_eddsa #(
    parameter int WIDTH = 64,
    parameter int MODE  = 512,
    parameter int LEN_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    input  logic [WIDTH-1:0]           msg_data,
    input  logic                       msg_last,
    input  logic [$clog2(WIDTH/8):0]   msg_last_bytes,
    output logic                       core_rst,
    output logic                       core_load,
    output logic                       core_start,
    output logic [WIDTH-1:0]           core_data,
    input  logic                       core_end_op,
    input  logic [8*WIDTH-1:0]         core_h,
    output logic [8*WIDTH-1:0]         digest,
    output logic                       digest_valid,
    output logic                       busy
);

    localparam int BPW  = WIDTH / 8;
    localparam int LB_W = $clog2(BPW) + 1;
    localparam logic [WIDTH-1:0] MARK = {8'h80, {(WIDTH-8){1'b0}}};

    // The round count follows from MODE but the core reports completion
    // itself, so MODE only has to agree with WIDTH.
    if ((((MODE == 224) || (MODE == 256)) ? 32 : 64) != WIDTH) begin : g_width_mode_mismatch
    end

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FILL, S_PAD, S_LOAD, S_RUN, S_SETTLE, S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   blk_buf [16];
    logic [3:0]         widx;
    logic [3:0]         kidx;
    logic [LEN_W-4:0]   len_bytes;
    logic               pend80;
    logic               final_blk;
    logic               msg_done;
    logic               init_pulse;

    logic [WIDTH-1:0]   last_word;
    logic [WIDTH-1:0]   pad_word;
    logic [LEN_W-4:0]   len_add;
    logic [LEN_W-1:0]   bit_len;
    logic [2*WIDTH-1:0] len_field;

    assign core_rst = rst & ~init_pulse;

    always_comb begin
        // Final word: keep the valid leading bytes, terminate with 0x80, zero the rest.
        last_word = '0;
        for (int b = 0; b < BPW; b++) begin
            if (b < int'(msg_last_bytes)) begin
                last_word[WIDTH-1-8*b -: 8] = msg_data[WIDTH-1-8*b -: 8];
            end else if (b == int'(msg_last_bytes)) begin
                last_word[WIDTH-1-8*b -: 8] = 8'h80;
            end
        end

        len_add   = msg_last ? (LEN_W-3)'(msg_last_bytes) : (LEN_W-3)'(BPW);
        bit_len   = {len_bytes, 3'b000};
        len_field = (2*WIDTH)'(bit_len);

        // Length lands in words 14..15 only once the 0x80 marker is already in
        // place; final_blk records that word 14 took the upper half.
        if (pend80) begin
            pad_word = MARK;
        end else if (widx == 4'd14) begin
            pad_word = len_field[2*WIDTH-1 -: WIDTH];
        end else if ((widx == 4'd15) && final_blk) begin
            pad_word = len_field[WIDTH-1:0];
        end else begin
            pad_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
            widx         <= '0;
            kidx         <= '0;
            len_bytes    <= '0;
            pend80       <= 1'b0;
            final_blk    <= 1'b0;
            msg_done     <= 1'b0;
            init_pulse   <= 1'b0;
            msg_ready    <= 1'b0;
            core_load    <= 1'b0;
            core_start   <= 1'b0;
            core_data    <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            init_pulse   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (msg_valid) begin
                        init_pulse <= 1'b1;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    len_bytes <= '0;
                    pend80    <= 1'b0;
                    final_blk <= 1'b0;
                    msg_done  <= 1'b0;
                    widx      <= '0;
                    msg_ready <= 1'b1;
                    state     <= S_FILL;
                end
                S_FILL: begin
                    if (msg_valid && msg_ready) begin
                        busy          <= 1'b1;
                        blk_buf[widx] <= msg_last ? last_word : msg_data;
                        widx          <= widx + 4'd1;
                        len_bytes     <= len_bytes + len_add;
                        if (msg_last) begin
                            msg_done  <= 1'b1;
                            pend80    <= (msg_last_bytes == LB_W'(BPW));
                            msg_ready <= 1'b0;
                        end else if (widx == 4'd15) begin
                            msg_ready <= 1'b0;
                        end
                        // A full block always goes to the core; padding then
                        // resumes from word 0 of the next block.
                        if (widx == 4'd15) begin
                            core_load <= 1'b1;
                            core_data <= blk_buf[0];
                            kidx      <= 4'd1;
                            state     <= S_LOAD;
                        end else if (msg_last) begin
                            state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    blk_buf[widx] <= pad_word;
                    widx          <= widx + 4'd1;
                    if (pend80) pend80 <= 1'b0;
                    if ((widx == 4'd14) && !pend80) final_blk <= 1'b1;
                    if (widx == 4'd15) begin
                        core_load <= 1'b1;
                        core_data <= blk_buf[0];
                        kidx      <= 4'd1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // kidx wraps to 0 once words 1..15 have been presented.
                    if (kidx == 4'd0) begin
                        core_load  <= 1'b0;
                        core_start <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        core_data <= blk_buf[kidx];
                        kidx      <= kidx + 4'd1;
                    end
                end
                S_RUN: begin
                    if (core_end_op) begin
                        core_start <= 1'b0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    widx <= '0;
                    if (final_blk) begin
                        state <= S_DONE;
                    end else if (msg_done) begin
                        state <= S_PAD;
                    end else begin
                        msg_ready <= 1'b1;
                        state     <= S_FILL;
                    end
                end
                S_DONE: begin
                    digest       <= core_h;
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_pad_feeder_eddsa.sv
// tb/tb_sha2_pad_feeder_eddsa.sv - self-checking bench for sha2_pad_feeder_eddsa
module tb_sha2_pad_feeder_eddsa;

    localparam int ROUNDS = 80;
    localparam logic [511:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [63:0]  msg_data = '0;
    logic         msg_last = 1'b0;
    logic [3:0]   msg_last_bytes = '0;
    logic         core_rst;
    logic         core_load;
    logic         core_start;
    logic [63:0]  core_data;
    logic         core_end_op;
    logic [511:0] core_h;
    logic [511:0] digest;
    logic         digest_valid;
    logic         busy;

    sha2_pad_feeder_eddsa #(.WIDTH(64), .MODE(512), .LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_last(msg_last), .msg_last_bytes(msg_last_bytes),
        .core_rst(core_rst), .core_load(core_load), .core_start(core_start),
        .core_data(core_data), .core_end_op(core_end_op), .core_h(core_h),
        .digest(digest), .digest_valid(digest_valid), .busy(busy));

    always #5 clk = ~clk;

    // Stand-in core: same handshake as the real one, cheap mixing function.
    logic [511:0]  h_reg;
    logic [1023:0] w_reg;
    int            rcnt;
    int            wk;

    function automatic logic [511:0] mix(logic [511:0] h, logic [1023:0] w);
        logic [511:0] r;
        logic [63:0]  hj, a, b, c;
        for (int j = 0; j < 8; j++) begin
            hj = h[511-64*j -: 64];
            a  = w[1023-64*j -: 64];
            b  = w[1023-64*(15-j) -: 64];
            c  = w[1023-64*(j+8) -: 64];
            r[511-64*j -: 64] = {hj[62:0], hj[63]} + (a ^ b) + {c[31:0], c[63:32]} + 64'(j);
        end
        return r;
    endfunction

    assign core_end_op = core_start && (rcnt == ROUNDS - 1);
    assign core_h      = h_reg;

    always @(posedge clk) begin
        if (!core_rst) begin
            h_reg <= IV;
            w_reg <= '0;
            rcnt  <= 0;
            wk    <= 0;
        end else begin
            if (core_load) begin
                w_reg[1023-64*wk -: 64] <= core_data;
                wk <= (wk + 1) % 16;
            end
            if (core_start) rcnt <= core_end_op ? 0 : rcnt + 1;
            if (core_end_op) h_reg <= mix(h_reg, w_reg);
        end
    end

    int           total = 0;
    int           bad = 0;
    logic [63:0]  exp_words[$];
    logic [511:0] exp_dig[$];
    logic [63:0]  seen[$];
    int           dv_count = 0;
    int           blk_count = 0;
    int           load_run = 0;
    int           start_run = 0;

    task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check512(string name, logic [511:0] act, logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] seen_at(int i);
        if (i < seen.size()) return seen[i];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                load_run  = 0;
                start_run = 0;
                continue;
            end
            if (core_load) begin
                seen.push_back(core_data);
                load_run++;
                if (exp_words.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL load_word: got %h expected none", core_data);
                end else begin
                    check64("load_word", core_data, exp_words.pop_front());
                end
            end else if (load_run != 0) begin
                check_int("load_len", load_run, 16);
                blk_count++;
                load_run = 0;
            end
            if (core_start) begin
                start_run++;
            end else if (start_run != 0) begin
                check_int("run_len", start_run, ROUNDS);
                start_run = 0;
            end
            if (digest_valid) begin
                dv_count++;
                if (exp_dig.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL digest: got %h expected none", digest);
                end else begin
                    check512("digest", digest, exp_dig.pop_front());
                end
            end
        end
    endtask

    // Builds the expected padded blocks and digest, then drives the words.
    task automatic send_msg(int nbytes, int gap);
        logic [7:0]    m[$];
        logic [7:0]    p[$];
        logic [63:0]   d;
        logic [1023:0] bw;
        logic [511:0]  hx;
        logic [63:0]   bitlen;
        int            nw, lb, cnt;
        for (int i = 0; i < nbytes; i++) begin
            if (nbytes == 3) m.push_back(8'h61 + 8'(i));
            else             m.push_back(8'(i*13 + nbytes*5 + 1));
        end
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 128) != 112) p.push_back(8'h00);
        bitlen = 64'(nbytes) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bitlen[63-8*i -: 8]);
        hx = IV;
        for (int blk = 0; blk < p.size() / 128; blk++) begin
            for (int k = 0; k < 16; k++) begin
                for (int b = 0; b < 8; b++) d[63-8*b -: 8] = p[blk*128 + k*8 + b];
                exp_words.push_back(d);
                bw[1023-64*k -: 64] = d;
            end
            hx = mix(hx, bw);
        end
        exp_dig.push_back(hx);
        seen.delete();

        nw = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            if ($urandom_range(99) < gap) begin
                msg_valid = 1'b0;
                step();
            end
            d = {8{8'hEE}};
            for (int b = 0; b < 8; b++) if (8*w + b < nbytes) d[63-8*b -: 8] = m[8*w + b];
            lb = (w == nw - 1) ? nbytes - 8*w : 8;
            msg_valid      = 1'b1;
            msg_data       = d;
            msg_last       = (w == nw - 1);
            msg_last_bytes = 4'(lb);
            cnt = 0;
            while (!msg_ready && cnt < 2000) begin
                step();
                cnt++;
            end
            if (!msg_ready) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready=0 expected ready=1 word=%0d", w);
            end
            step();
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_digest(int start);
        for (int c = 0; c < 5000 && dv_count == start; c++) step();
        if (dv_count == start) begin
            total++;
            bad++;
            $display("FAIL digest_timeout: got %0d pulses expected %0d", dv_count - start, 1);
        end
    endtask

    typedef struct {
        int nbytes;
        int gap;
        int exp_blocks;
    } vec_t;

    vec_t         vecs[11];
    logic [511:0] dig128;
    int           dv0, blk0;

    initial begin
        vecs[0]  = '{3,   0,  1};
        vecs[1]  = '{0,   0,  1};
        vecs[2]  = '{8,   0,  1};
        vecs[3]  = '{111, 0,  1};
        vecs[4]  = '{112, 0,  2};
        vecs[5]  = '{119, 30, 2};
        vecs[6]  = '{127, 0,  2};
        vecs[7]  = '{128, 0,  2};
        vecs[8]  = '{128, 50, 2};
        vecs[9]  = '{240, 40, 3};
        vecs[10] = '{13,  50, 1};
        dig128 = '0;

        fork
            monitor();
        join_none

        repeat (3) step();
        check_int("rst_msg_ready", int'(msg_ready), 0);
        check_int("rst_core_load", int'(core_load), 0);
        check_int("rst_core_start", int'(core_start), 0);
        check_int("rst_core_rst", int'(core_rst), 0);
        check_int("rst_digest_valid", int'(digest_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check512("rst_digest", digest, '0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            dv0  = dv_count;
            blk0 = blk_count;
            send_msg(vecs[i].nbytes, vecs[i].gap);
            check_int("busy_during", int'(busy), 1);
            wait_digest(dv0);
            repeat (5) step();
            check_int("dv_once", dv_count - dv0, 1);
            check_int("blocks", blk_count - blk0, vecs[i].exp_blocks);
            check_int("words_left", exp_words.size(), 0);
            check_int("busy_after", int'(busy), 0);
            case (vecs[i].nbytes)
                3: begin
                    check64("abc_w0", seen_at(0), 64'h6162638000000000);
                    check64("abc_w15", seen_at(15), 64'h18);
                end
                0: begin
                    check64("empty_w0", seen_at(0), 64'h8000000000000000);
                    check64("empty_w15", seen_at(15), 64'h0);
                end
                112: begin
                    check64("b112_w14", seen_at(14), 64'h8000000000000000);
                    check64("b112_b2w0", seen_at(16), 64'h0);
                    check64("b112_b2w15", seen_at(31), 64'h380);
                end
                128: begin
                    check64("b128_b2w0", seen_at(16), 64'h8000000000000000);
                    check64("b128_b2w15", seen_at(31), 64'h400);
                    if (vecs[i].gap == 0) dig128 = digest;
                    else check512("backpressure_digest", digest, dig128);
                end
                default: ;
            endcase
            exp_words.delete();
            exp_dig.delete();
        end

        // Reset while the core is running: no digest, outputs back to reset values.
        send_msg(3, 0);
        for (int c = 0; c < 3000 && !core_start; c++) step();
        check_int("abort_reached_run", int'(core_start), 1);
        repeat (10) step();
        dv0 = dv_count;
        rst = 1'b0;
        step();
        check_int("abort_msg_ready", int'(msg_ready), 0);
        check_int("abort_core_load", int'(core_load), 0);
        check_int("abort_core_start", int'(core_start), 0);
        check_int("abort_core_rst", int'(core_rst), 0);
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_dv", int'(digest_valid), 0);
        check512("abort_digest", digest, '0);
        exp_words.delete();
        exp_dig.delete();
        rst = 1'b1;
        repeat (100) step();
        check_int("abort_no_digest", dv_count - dv0, 0);

        dv0 = dv_count;
        send_msg(3, 0);
        wait_digest(dv0);
        repeat (5) step();
        check_int("post_abort_dv", dv_count - dv0, 1);
        check64("post_abort_w0", seen_at(0), 64'h6162638000000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha2_pad_feeder_eddsa.md
Name: sha2_pad_feeder_eddsa

Overview:
Upstream stage of the SHA-2 core used by the EdDSA datapath. It accepts a big-endian message word stream, performs FIPS 180-4 padding and length append, and assembles 16-word blocks. It drives each block into the core (load phase, then start phase), sequences multi-block messages, and registers the final digest. It owns the core's reset, so each new message starts from the IV.

Parameters:
WIDTH, 64, word width (32 for SHA-224/256, 64 for SHA-384/512); must match the core.
MODE, 512, SHA-2 variant; selects round count ROUNDS (64 for 224/256, 80 for 384/512).
LEN_W, 64, width of the internal bit-length counter; length field bits above LEN_W are zero.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
msg_valid  in  1  input word valid
msg_ready  out  1  input word accepted when msg_valid & msg_ready
msg_data  in  WIDTH  message word; first byte in MSBs
msg_last  in  1  marks final word of message
msg_last_bytes  in  $clog2(WIDTH/8)+1  valid bytes in the final word, 0..WIDTH/8 (0 = word carries no bytes; allows the empty message)
core_rst  out  1  active-low reset to the core = rst & ~init_pulse
core_load  out  1  core load strobe
core_start  out  1  core round enable
core_data  out  WIDTH  word presented to core data_in
core_end_op  in  1  core end_op
core_h  in  8*WIDTH  core H_out
digest  out  8*WIDTH  registered digest
digest_valid  out  1  one-cycle pulse when digest is updated
busy  out  1  high from first accepted word until digest_valid

Behaviour:
- Reset (rst=0): state IDLE. msg_ready=0, core_load=0, core_start=0, digest=0, digest_valid=0, busy=0. Buffer and counters are cleared. A reset mid-message aborts the message with no digest. core_rst follows rst.
- Buffer: 16 x WIDTH registers buf[0..15], write index widx[3:0], byte counter len_bytes[LEN_W-4:0], flags pend80 and final_blk.
- IDLE: msg_ready=0. On msg_valid, go to INIT.
- INIT: 1 cycle, init_pulse=1 (core_rst=0), which restores the core IV. Clear len and flags, then go to FILL.
- FILL: msg_ready=1. Each accepted word is written to buf[widx], widx increments, and len_bytes increments by WIDTH/8, or by msg_last_bytes when msg_last=1.
  - A non-last word written at widx=15 drops msg_ready and goes to LOAD with final_blk=0.
  - On the last word: bytes at positions >= msg_last_bytes are replaced by 0x80 followed by zeros.
  - If msg_last_bytes == WIDTH/8, the 0x80 is placed in the next word instead (pend80=1).
  - Then go to PAD.
- PAD: fill remaining words one per cycle.
  - A pending 0x80 goes in MSB byte position; all other words are 0.
  - If the first free index after the 0x80 is <= 14: words 14..15 hold the bit length (len_bytes<<3) as a 2*WIDTH big-endian value, and final_blk=1.
  - Otherwise zero-fill to 15 with final_blk=0. The next block is all zeros (carrying 0x80 in word 0 if still pending) plus the length in words 14..15.
- LOAD: 16 cycles, core_load=1, core_start=0, core_data=buf[k] for k=0..15 in order.
- RUN: core_load=0, core_start=1 until core_end_op=1 is sampled.
- SETTLE: 1 cycle with core_start=0, so the core commits H_ini before the next load or digest capture.
  - If final_blk=0, go to FILL (or directly to PAD if the message already ended). widx is reset to 0.
  - If final_blk=1, go to DONE.
- DONE: digest <= core_h, digest_valid=1 for one cycle, busy=0, then IDLE. digest holds until the next digest_valid or reset.
- msg_valid while not in FILL is ignored. msg_last at widx=15 is handled as normal (padding spills into the next block).
- Per-block latency from first LOAD cycle to SETTLE exit: 16 + ROUNDS + 1 cycles.

Test Plan:
- SHA-512 "abc": one word 0x6162630000000000, last_bytes=3 -> single block. buf[0]=0x6162638000000000, buf[15]=0x18. digest begins 0xddaf35a193617aba, ends 0xa54ca49f.
- Empty message: msg_last, last_bytes=0 -> buf[0]=0x8000000000000000, length 0. digest begins 0xcf83e1357eefb8bd.
- 112-byte message (14 full words) -> 0x80 in word 14, overflow. Two blocks; second block is zeros with 0x380 in word 15. digest_valid exactly once.
- 128-byte message (16 full words) -> second block word 0 = 0x8000000000000000, word 15 = 0x400.
- Backpressure: msg_valid toggled randomly during FILL -> same digest as the gapless case. core_load is high for exactly 16 consecutive cycles per block.
- rst=0 during RUN -> all outputs at reset values next cycle. A subsequent "abc" message yields the correct digest.
